seg7_count_display: RTL and testbench

SEG7_COUNT_DISPLAY -- requirements
Module: seg7_count_display

---
 rtl/seg7_pkg.sv | 45 ++++
 rtl/bin2bcd_seq.sv | 72 +++++++
 rtl/seg7_count_display.sv | 169 ++++++++++++++++
 tb/tb_seg7_count_display.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment count display.
//   - conv_state_t : converter FSM states (IDLE, SHIFT, LOAD)
//   - SEG_0..SEG_9, SEG_BLANK, SEG_MINUS : active-low segment codes, bit order gfedcba
//   - NUM_DIGITS   : number of multiplexed digits
//   - seg_decode() : BCD digit to segment code
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } conv_state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, 8-bit binary to 3-digit BCD.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : accepted only in IDLE; captures bin and begins a conversion
//   bin[7:0]   : binary magnitude to convert
//   bcd[11:0]  : hundreds/tens/units; final only while done is high
//   done       : high for the single LOAD cycle
//   busy       : high in SHIFT and LOAD
// Timing: start seen in IDLE -> 8 SHIFT cycles -> 1 LOAD cycle -> IDLE.
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic [11:0] bcd,
  output logic        done,
  output logic        busy
);

  conv_state_t state;
  logic [7:0]  shreg;
  logic [11:0] acc;
  logic [11:0] acc_adj;
  logic [2:0]  iter;

  // Add 3 to every nibble that is 5 or more so the following shift carries
  // correctly into the next decimal digit.
  function automatic logic [11:0] dabble_adjust(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    if (r[3:0]  >= 4'd5) r[3:0]  = r[3:0]  + 4'd3;
    if (r[7:4]  >= 4'd5) r[7:4]  = r[7:4]  + 4'd3;
    if (r[11:8] >= 4'd5) r[11:8] = r[11:8] + 4'd3;
    return r;
  endfunction

  assign acc_adj = dabble_adjust(acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      acc   <= '0;
      iter  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg <= bin;
            acc   <= '0;
            iter  <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          {acc, shreg} <= {acc_adj[10:0], shreg, 1'b0};
          iter         <= iter + 3'd1;
          if (iter == 3'd7) state <= LOAD;
        end
        LOAD:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bcd  = acc;
  assign done = (state == LOAD);
  assign busy = (state != IDLE);

endmodule

// File: rtl/seg7_count_display.sv
// seg7_count_display: shows an 8-bit count on a 4-digit multiplexed,
// active-low 7-segment display with leading-zero blanking.
// Parameters: CLK_HZ (input clock, Hz), SCAN_HZ (per-digit refresh, Hz).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   value[7:0] : count to display
//   seg[6:0]   : segments, active-low, gfedcba (bit 0 = a)
//   an[3:0]    : digit anodes, active-low, an[0] = rightmost (units)
//   busy       : high while a binary-to-BCD conversion is in progress
// Build option: define SEG7_SIGNED_EN to treat value as two's complement and
// show a minus sign on digit 3; otherwise value is unsigned and digit 3 stays blank.
module seg7_count_display
  import seg7_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] value,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       busy
);

  localparam int DIV_RAW = CLK_HZ / SCAN_HZ;
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  // ---- scan divider and digit index ----
  logic [DIV_W-1:0] div_cnt;
  logic             scan_en;
  logic [IDX_W-1:0] dig_idx;
  logic [IDX_W-1:0] dig_idx_nxt;

  assign scan_en     = (div_cnt == DIV_LAST);
  assign dig_idx_nxt = scan_en ? dig_idx + 1'b1 : dig_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      dig_idx <= '0;
    end else begin
      div_cnt <= scan_en ? '0 : div_cnt + 1'b1;
      dig_idx <= dig_idx_nxt;
    end
  end

  // ---- change detection and conversion ----
  logic [7:0]  last_val;
  logic [7:0]  mag;
  logic        start;
  logic [11:0] bcd;
  logic        conv_done;

  // A change arriving mid-conversion simply waits: start is re-evaluated
  // against last_val on the first IDLE cycle.
  assign start = !busy && (value != last_val);

`ifdef SEG7_SIGNED_EN
  logic signed [7:0] value_s;
  logic              sign_cap;
  logic              sign_d;
  logic              sign_nxt;

  // -128 negates to itself; read as unsigned that is the magnitude 128.
  assign value_s = value;
  assign mag     = (value_s < 0) ? $unsigned(-value_s) : value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_cap <= 1'b0;
      sign_d   <= 1'b0;
    end else begin
      if (start)     sign_cap <= value[7];
      if (conv_done) sign_d   <= sign_cap;
    end
  end

  assign sign_nxt = conv_done ? sign_cap : sign_d;
`else
  assign mag = value;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_val <= '0;
    else if (start) last_val <= value;
  end

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (mag),
    .bcd   (bcd),
    .done  (conv_done),
    .busy  (busy)
  );

  // ---- display registers (loaded only with a finished conversion) ----
  logic [3:0] hund_d, tens_d, unit_d;
  logic [3:0] hund_nxt, tens_nxt, unit_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hund_d <= '0;
      tens_d <= '0;
      unit_d <= '0;
    end else if (conv_done) begin
      hund_d <= bcd[11:8];
      tens_d <= bcd[7:4];
      unit_d <= bcd[3:0];
    end
  end

  // Outputs are built from the values the registers will hold after this
  // edge, so a scan step coinciding with a load shows the new result.
  assign hund_nxt = conv_done ? bcd[11:8] : hund_d;
  assign tens_nxt = conv_done ? bcd[7:4]  : tens_d;
  assign unit_nxt = conv_done ? bcd[3:0]  : unit_d;

  // ---- blanking and output registers ----
  logic [6:0] seg_nxt;
  logic [3:0] an_nxt;

  always_comb begin
    seg_nxt = SEG_BLANK;
    an_nxt  = 4'b1111;
    case (dig_idx_nxt)
      2'd0: begin
        seg_nxt = seg_decode(unit_nxt);
        an_nxt  = 4'b1110;
      end
      2'd1: begin
        if (hund_nxt != 4'd0 || tens_nxt != 4'd0) begin
          seg_nxt = seg_decode(tens_nxt);
          an_nxt  = 4'b1101;
        end
      end
      2'd2: begin
        if (hund_nxt != 4'd0) begin
          seg_nxt = seg_decode(hund_nxt);
          an_nxt  = 4'b1011;
        end
      end
      default: begin
`ifdef SEG7_SIGNED_EN
        if (sign_nxt) begin
          seg_nxt = SEG_MINUS;
          an_nxt  = 4'b0111;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_BLANK;
      an  <= 4'b1111;
    end else if (scan_en || conv_done) begin
      seg <= seg_nxt;
      an  <= an_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_count_display.sv
// tb_seg7_count_display: scoreboard bench for seg7_count_display with
// CLK_HZ = 4000, SCAN_HZ = 1000 (one scan step every 4 clocks).
// Stimulus pushes hand-computed {an, seg} expectations tagged with the scan
// step they belong to; a monitor pops and compares at each scan step.
module tb_seg7_count_display;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] value = 8'd0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       busy;

  always #5 clk = ~clk;

  seg7_count_display #(.CLK_HZ(4000), .SCAN_HZ(1000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .value (value),
    .seg   (seg),
    .an    (an),
    .busy  (busy)
  );

  // Hand-written segment codes (gfedcba, active-low)
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000, S5 = 7'b0010010, S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0010000;
  localparam logic [6:0] BL = 7'b1111111, MI = 7'b0111111;
  localparam logic [3:0] A0 = 4'b1110, A1 = 4'b1101, A2 = 4'b1011, A3 = 4'b0111, AN = 4'b1111;
  localparam logic [10:0] OFF = {4'b1111, 7'b1111111};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Bench-side clock count since reset release; scan steps land on multiples of 4.
  int cyc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  typedef struct {
    int          step;
    logic [10:0] exp;
    string       name;
  } exp_t;
  exp_t sb[$];

  // Monitor: compare the output presented at each scan step.
  always @(negedge clk) begin : monitor
    int   s;
    exp_t e;
    if (rst_n && cyc > 0 && (cyc % 4) == 0) begin
      s = cyc / 4;
      while (sb.size() > 0 && sb[0].step < s) begin
        e = sb.pop_front();
        check({"missed_", e.name}, 32'(s), 32'(e.step));
      end
      if (sb.size() > 0 && sb[0].step == s) begin
        e = sb.pop_front();
        check(e.name, {21'd0, an, seg}, {21'd0, e.exp});
      end
    end
  end

  // Busy activity and stray-anode watchers
  int   busy_cyc = 0;
  int   busy_rise = 0;
  int   an_hi_low = 0;
  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    if (busy === 1'b1) busy_cyc++;
    if (busy === 1'b1 && busy_prev !== 1'b1) busy_rise++;
    if (an[3:1] !== 3'b111) an_hi_low++;
    busy_prev = busy;
  end

  task automatic clr_watch();
    busy_cyc = 0; busy_rise = 0; an_hi_low = 0;
  endtask

  // Push expectations for n consecutive steps starting at s0, picking the
  // pattern of whichever digit the scan is on at each step.
  task automatic push_seq(input string name, input int s0, input int n,
                          input logic [10:0] d0, input logic [10:0] d1,
                          input logic [10:0] d2, input logic [10:0] d3);
    logic [10:0] pat [4];
    exp_t e;
    pat[0] = d0; pat[1] = d1; pat[2] = d2; pat[3] = d3;
    for (int k = 0; k < n; k++) begin
      e.step = s0 + k;
      e.exp  = pat[(s0 + k) % 4];
      e.name = $sformatf("%s_d%0d", name, (s0 + k) % 4);
      sb.push_back(e);
    end
  endtask

  task automatic push_rot(input string name, input logic [10:0] d0, input logic [10:0] d1,
                          input logic [10:0] d2, input logic [10:0] d3);
    push_seq(name, cyc / 4 + 2, 4, d0, d1, d2, d3);
  endtask

  task automatic wait_sb_empty();
    for (int i = 0; i < 200 && sb.size() > 0; i++) @(posedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic align_phase(input int r);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if ((cyc % 4) == r) break;
    end
  endtask

  task automatic apply(input logic [7:0] v, input string name,
                       input logic [10:0] d0, input logic [10:0] d1,
                       input logic [10:0] d2, input logic [10:0] d3);
    @(posedge clk); #1;
    value = v;
    repeat (14) @(posedge clk);
    #1;
    push_rot(name, d0, d1, d2, d3);
    wait_sb_empty();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int sa;
    // Reset state while rst_n is low
    rst_n = 1'b0;
    value = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", 32'(an), 32'(AN));
    check("rst_seg", 32'(seg), 32'(BL));
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Value 0 after reset: units "0", everything else dark, no conversion
    clr_watch();
    @(posedge clk); #1;
    push_rot("zero", {A0, S0}, OFF, OFF, OFF);
    wait_sb_empty();
    check("zero_busy", 32'(busy_cyc), 32'd0);

    // 5 -> 255 -> 9 back to back: 255 is never captured
    @(posedge clk); #1;
    clr_watch();
    value = 8'd5;
    @(posedge clk); #1;
    value = 8'd255;
    @(posedge clk); #1;
    value = 8'd9;
    repeat (30) @(posedge clk);
    #1;
    check("b2b_busy_cycles", 32'(busy_cyc), 32'd18);
    check("b2b_conversions", 32'(busy_rise), 32'd2);
    check("b2b_only_an0", 32'(an_hi_low), 32'd0);
    push_rot("nine", {A0, S9}, OFF, OFF, OFF);
    wait_sb_empty();

    // 9 -> 173: busy for 9 cycles, display switches 10 cycles after detection
    align_phase(2);
    clr_watch();
    value = 8'd173;
    sa = (cyc + 6) / 4;
    push_seq("old9", sa, 1, {A0, S9}, OFF, OFF, OFF);
    push_seq("new173", sa + 1, 1, {A0, S3}, {A1, S7}, {A2, S1}, OFF);
    repeat (16) @(posedge clk);
    #1;
    check("c173_busy_cycles", 32'(busy_cyc), 32'd9);
    check("c173_conversions", 32'(busy_rise), 32'd1);
    wait_sb_empty();
    push_rot("v173", {A0, S3}, {A1, S7}, {A2, S1}, OFF);
    wait_sb_empty();

    // Blanking boundaries
    apply(8'd100, "v100", {A0, S0}, {A1, S0}, {A2, S1}, OFF);
    apply(8'd20,  "v20",  {A0, S0}, {A1, S2}, OFF, OFF);
`ifdef SEG7_SIGNED_EN
    apply(8'h80, "vm128", {A0, S8}, {A1, S2}, {A2, S1}, {A3, MI});
    apply(8'hFF, "vm1",   {A0, S1}, OFF, OFF, {A3, MI});
    apply(8'h7F, "v127",  {A0, S7}, {A1, S2}, {A2, S1}, OFF);
`else
    apply(8'd255, "v255", {A0, S5}, {A1, S5}, {A2, S2}, OFF);
    apply(8'd8,   "v8",   {A0, S8}, OFF, OFF, OFF);
`endif

    // Reset pulsed mid-SHIFT: immediate reset outputs, conversion discarded
    @(posedge clk); #1;
    value = 8'd42;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_an", 32'(an), 32'(AN));
    check("mid_rst_seg", 32'(seg), 32'(BL));
    check("mid_rst_busy", 32'(busy), 32'd0);
    value = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    clr_watch();
    @(posedge clk); #1;
    push_rot("post_rst", {A0, S0}, OFF, OFF, OFF);
    wait_sb_empty();
    check("post_rst_busy", 32'(busy_cyc), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
